seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.

---
 rtl/seg_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller.
// Blanking dead-time per slot and frame-boundary commit of the host shadow registers.
module seg_scan_ctrl #(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    input  logic [3:0]  wr_blank,
    output logic        wr_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLK  = CW'(BLANK_CYC);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]  idx, idx_n;
    logic        pending, pending_n;
    logic [15:0] sh_data, act_data, act_data_n;
    logic [3:0]  sh_dp, act_dp, act_dp_n;
    logic [3:0]  sh_blank, act_blank, act_blank_n;
    logic        slot_end, wrap, accept, commit;
    logic [3:0]  an_d, nib;
    logic [6:0]  seg_d;
    logic        dp_d;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign wr_ready = ~pending;

    // Slot timing, handshake and commit decode (all next-state values)
    always_comb begin
        slot_end    = en && (cnt == LAST);
        wrap        = slot_end && (idx == 2'd3);
        accept      = wr_en && !pending;
        commit      = pending && (!en || wrap);
        cnt_n       = (!en || slot_end) ? '0 : cnt + CW'(1);
        idx_n       = !en ? 2'd0 : (slot_end ? idx + 2'd1 : idx);
        pending_n   = accept ? 1'b1 : (commit ? 1'b0 : pending);
        act_data_n  = commit ? sh_data  : act_data;
        act_dp_n    = commit ? sh_dp    : act_dp;
        act_blank_n = commit ? sh_blank : act_blank;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BLANK;
            cnt       <= '0;
            idx       <= 2'd0;
            pending   <= 1'b0;
            sh_data   <= 16'h0;
            sh_dp     <= 4'h0;
            sh_blank  <= 4'hF;
            act_data  <= 16'h0;
            act_dp    <= 4'h0;
            act_blank <= 4'hF;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            pending   <= pending_n;
            act_data  <= act_data_n;
            act_dp    <= act_dp_n;
            act_blank <= act_blank_n;
            if (accept) begin
                sh_data  <= wr_data;
                sh_dp    <= wr_dp;
                sh_blank <= wr_blank;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            BLANK: if (en && cnt_n >= BLK) state_n = SHOW;
            SHOW:  if (!en || cnt_n < BLK) state_n = BLANK;
            default: state_n = BLANK;
        endcase
    end

    // Decode the upcoming cycle so the output flops match that cycle's cnt/idx
    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        nib   = act_data_n[{idx_n, 2'b00} +: 4];
        if (state_n == SHOW) begin
            an_d = ~(4'b0001 << idx_n);
            if (!act_blank_n[idx_n]) begin
                seg_d = hex7(nib);
                dp_d  = ~act_dp_n[idx_n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at TICK_DIV=8, BLANK_CYC=2.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic [3:0]  wr_blank;
    logic        wr_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(.TICK_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
        .wr_blank(wr_blank), .wr_ready(wr_ready),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        we;
        logic [15:0] d;
        logic [3:0]  dpv;
        logic [3:0]  bl;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        rdy;
        logic        ft;
    } vec_t;

    vec_t tv[12];

    function automatic logic [6:0] hexs(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;  default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_disp(input string name, input logic [3:0] ea,
                            input logic [6:0] es, input logic ed);
        chk({name, ".an"}, {12'h0, an}, {12'h0, ea});
        chk({name, ".seg"}, {9'h0, seg}, {9'h0, es});
        chk({name, ".dp"}, {15'h0, dp}, {15'h0, ed});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [15:0] d, input logic [3:0] p,
                      input logic [3:0] b);
        wr_en = 1'b1; wr_data = d; wr_dp = p; wr_blank = b;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_ft();
        int i;
        step();
        i = 0;
        while (frame_tick !== 1'b1 && i < 40) begin
            step();
            i++;
        end
        chk("wait_ft", {15'h0, frame_tick}, 16'h1);
    endtask

    initial begin
        logic [15:0] dat;
        logic [3:0]  dpm;
        logic [3:0]  ea;
        logic [6:0]  es;
        logic        ed;
        int          s;
        int          c;

        rst_n = 1'b0; en = 1'b0; wr_en = 1'b0;
        wr_data = 16'h0; wr_dp = 4'h0; wr_blank = 4'h0;

        tv[0]  = '{1'b0, 1'b1, 16'h1234, 4'b0001, 4'b0000, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 16'hFFFF, 4'b1111, 4'b1111, 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0};
        tv[3]  = '{1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'hE, 7'b0011001, 1'b0, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'hE, 7'b0011001, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'hE, 7'b0011001, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'hE, 7'b0011001, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'hE, 7'b0011001, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'hE, 7'b0011001, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0};
        tv[10] = '{1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0};
        tv[11] = '{1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'hD, 7'b0110000, 1'b1, 1'b1, 1'b0};

        #12;
        chk_disp("reset", 4'hF, 7'h7F, 1'b1);
        chk("reset.rdy", {15'h0, wr_ready}, 16'h1);
        chk("reset.ft", {15'h0, frame_tick}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write while dark, ignored second write, then restart of the scan
        for (int i = 0; i < 12; i++) begin
            en = tv[i].en; wr_en = tv[i].we; wr_data = tv[i].d;
            wr_dp = tv[i].dpv; wr_blank = tv[i].bl;
            step();
            chk_disp($sformatf("vec%0d", i), tv[i].an, tv[i].seg, tv[i].dp);
            chk($sformatf("vec%0d.rdy", i), {15'h0, wr_ready}, {15'h0, tv[i].rdy});
            chk($sformatf("vec%0d.ft", i), {15'h0, frame_tick}, {15'h0, tv[i].ft});
        end
        wr_en = 1'b0;

        // One full frame of 1234 / dp0001, then frame period
        wait_ft();
        dat = 16'h1234;
        dpm = 4'b0001;
        for (int k = 0; k < 32; k++) begin
            s = k / 8;
            c = k % 8;
            if (c < 2) begin
                ea = 4'hF; es = 7'h7F; ed = 1'b1;
            end else begin
                ea = ~(4'b0001 << s);
                es = hexs(dat[s*4 +: 4]);
                ed = ~dpm[s];
            end
            chk_disp($sformatf("scan%0d", k), ea, es, ed);
            chk($sformatf("scan%0d.ft", k), {15'h0, frame_tick}, {15'h0, (k == 0)});
            step();
        end
        chk("ft_period", {15'h0, frame_tick}, 16'h1);

        // Write A, ignored B, C refused in the commit cycle then accepted
        wr(16'hABCD, 4'h0, 4'h0);
        chk("a.rdy", {15'h0, wr_ready}, 16'h0);
        wr(16'h5555, 4'hF, 4'h0);
        chk("b.rdy", {15'h0, wr_ready}, 16'h0);
        tick(29);
        chk("commit_cyc.rdy", {15'h0, wr_ready}, 16'h0);
        wr_en = 1'b1; wr_data = 16'h0F0F; wr_dp = 4'h0; wr_blank = 4'h0;
        step();
        chk("post_commit.ft", {15'h0, frame_tick}, 16'h1);
        chk("post_commit.rdy", {15'h0, wr_ready}, 16'h1);
        step();
        wr_en = 1'b0;
        chk("c.rdy", {15'h0, wr_ready}, 16'h0);
        tick(1);
        chk_disp("a.idx0", 4'hE, 7'b0100001, 1'b1);
        tick(24);
        chk_disp("a.idx3", 4'h7, 7'b0001000, 1'b1);
        tick(8);
        chk_disp("c.idx0", 4'hE, 7'b0001110, 1'b1);
        tick(8);
        chk_disp("c.idx1", 4'hD, 7'b1000000, 1'b1);

        // Per-digit blank mask
        wr(16'h8888, 4'h0, 4'b1000);
        wait_ft();
        tick(2);
        chk_disp("bl.idx0", 4'hE, 7'b0000000, 1'b1);
        tick(24);
        chk_disp("bl.idx3", 4'h7, 7'h7F, 1'b1);

        // Drop en mid-idx2 with a pending write, then restart
        wait_ft();
        tick(17);
        wr(16'h4321, 4'h0, 4'h0);
        chk("d.rdy", {15'h0, wr_ready}, 16'h0);
        tick(1);
        chk("d.mid_idx2", {12'h0, an}, 16'hB);
        en = 1'b0;
        step();
        chk_disp("d.dark", 4'hF, 7'h7F, 1'b1);
        chk("d.dark.ft", {15'h0, frame_tick}, 16'h0);
        step();
        chk("d.commit.rdy", {15'h0, wr_ready}, 16'h1);
        en = 1'b1;
        step();
        chk_disp("d.blank", 4'hF, 7'h7F, 1'b1);
        step();
        chk_disp("d.idx0", 4'hE, 7'b1111001, 1'b1);

        // Asynchronous reset mid-SHOW with a write pending
        wr(16'h9999, 4'h0, 4'h0);
        chk("e.rdy", {15'h0, wr_ready}, 16'h0);
        rst_n = 1'b0;
        #1;
        chk_disp("e.rst", 4'hF, 7'h7F, 1'b1);
        chk("e.rst.rdy", {15'h0, wr_ready}, 16'h1);
        chk("e.rst.ft", {15'h0, frame_tick}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        chk_disp("e.after", 4'hE, 7'h7F, 1'b1);
        chk("e.after.rdy", {15'h0, wr_ready}, 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
